dco_code_monitor: RTL

DCO_CODE_MONITOR -- requirements
Module: dco_code_monitor

---
 rtl/dco_code_monitor_if.sv | 37 +++
 rtl/dco_code_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dco_code_monitor_if.sv
// dco_code_monitor_if
//   Window-result handshake bundle of the DCO code monitor.
//   master : producer side (drives resultValid and the result fields, reads resultReady)
//   slave  : consumer side (reads resultValid and the result fields, drives resultReady)
//   Signals:
//     resultValid    a completed window result is being offered
//     resultReady    consumer accepts the offered result
//     resultSum      sum of the codes in the window
//     resultMin      smallest code in the window
//     resultMax      largest code in the window
//     resultChanges  number of code changes in the window (saturating)
interface dco_code_monitor_if;
    logic        resultValid;
    logic        resultReady;
    logic [19:0] resultSum;
    logic [7:0]  resultMin;
    logic [7:0]  resultMax;
    logic [11:0] resultChanges;

    modport master (
        output resultValid,
        output resultSum,
        output resultMin,
        output resultMax,
        output resultChanges,
        input  resultReady
    );

    modport slave (
        input  resultValid,
        input  resultSum,
        input  resultMin,
        input  resultMax,
        input  resultChanges,
        output resultReady
    );
endinterface

// File: rtl/dco_code_monitor.sv
// dco_code_monitor
//   Samples the active-low row/column thermometer codes driven to a DCO matrix,
//   decodes them into a binary code, and gathers per-window statistics
//   (sum, min, max, number of code changes) over 2^windowLog valid samples.
//   Ports:
//     referenceClock   clock, all state on the rising edge
//     reset_b          asynchronous active-low reset
//     enable           sampling enable; low clears the window in progress
//     dcoRowSelect     active-low row thermometer code
//     dcoColumnSelect  active-low column thermometer code
//     windowLog        log2 of the window length (clamped to 12)
//     clearFlags       clears formatError and overrun
//     currentCode      last valid decoded code
//     codeValid        currentCode updated this cycle
//     result           window-result handshake (master side)
//     formatError      sticky: a sample with a non-contiguous zero pattern was seen
//     overrun          sticky: a window result was dropped while one was pending
module dco_code_monitor #(
    parameter int unsigned NUM_DCO_MATRIX_COLUMNS = 15,
    parameter int unsigned NUM_DCO_MATRIX_ROWS    = 17
) (
    input  logic                              referenceClock,
    input  logic                              reset_b,
    input  logic                              enable,
    input  logic [NUM_DCO_MATRIX_ROWS-2:0]    dcoRowSelect,
    input  logic [NUM_DCO_MATRIX_COLUMNS-2:0] dcoColumnSelect,
    input  logic [3:0]                        windowLog,
    input  logic                              clearFlags,
    output logic [7:0]                        currentCode,
    output logic                              codeValid,
    dco_code_monitor_if.master                result,
    output logic                              formatError,
    output logic                              overrun
);

    localparam int unsigned RW    = NUM_DCO_MATRIX_ROWS - 1;
    localparam int unsigned CW    = NUM_DCO_MATRIX_COLUMNS - 1;
    localparam int unsigned RCW   = $clog2(RW + 1);
    localparam int unsigned CCW   = $clog2(CW + 1);
    localparam int unsigned CNT_W = 13;

    localparam logic [RW-1:0]    ROW_ONE = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    COL_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = 13'd1;

    // Stage 1 registers
    logic [RW-1:0] s1_row;
    logic [CW-1:0] s1_col;
    logic          s1_valid;

    // Window accumulators
    logic [CNT_W-1:0] win_cnt;
    logic [3:0]       win_log;
    logic [19:0]      acc_sum;
    logic [7:0]       acc_min;
    logic [7:0]       acc_max;
    logic [11:0]      acc_chg;
    logic             have_prev;

    // Decode / next-state signals
    logic [RW-1:0]    row_zeros;
    logic [CW-1:0]    col_zeros;
    logic [RCW-1:0]   row_cnt;
    logic [CCW-1:0]   col_cnt;
    logic             row_ok;
    logic             col_ok;
    logic [7:0]       dec_code;
    logic             sample_ok;
    logic             sample_bad;
    logic [3:0]       log_in;
    logic [3:0]       eff_log;
    logic             win_first;
    logic [CNT_W-1:0] win_target;
    logic [CNT_W-1:0] cnt_next;
    logic             complete;
    logic [19:0]      sum_base;
    logic [19:0]      sum_next;
    logic [7:0]       min_next;
    logic [7:0]       max_next;
    logic             is_change;
    logic [11:0]      chg_base;
    logic [11:0]      chg_next;
    logic             result_load;
    logic             overrun_set;

    always_comb begin
        row_zeros = ~s1_row;
        col_zeros = ~s1_col;

        row_cnt = '0;
        for (int unsigned i = 0; i < RW; i++) begin
            row_cnt = row_cnt + RCW'(row_zeros[i]);
        end
        col_cnt = '0;
        for (int unsigned i = 0; i < CW; i++) begin
            col_cnt = col_cnt + CCW'(col_zeros[i]);
        end

        // A zero mask contiguous from bit 0 has the form 0..01..1, so adding
        // one carries through it and leaves no overlapping bit.
        row_ok = ((row_zeros & (row_zeros + ROW_ONE)) == '0);
        col_ok = ((col_zeros & (col_zeros + COL_ONE)) == '0);

        dec_code = 8'(32'(row_cnt) * NUM_DCO_MATRIX_COLUMNS + 32'(col_cnt));

        sample_ok  = enable && s1_valid && row_ok && col_ok;
        sample_bad = enable && s1_valid && !(row_ok && col_ok);

        log_in     = (windowLog > 4'd12) ? 4'd12 : windowLog;
        win_first  = (win_cnt == '0);
        // The window length is taken live only for the first sample of a
        // window; afterwards the latched value is used.
        eff_log    = win_first ? log_in : win_log;
        win_target = CNT_ONE << eff_log;
        cnt_next   = win_cnt + CNT_ONE;
        complete   = sample_ok && (cnt_next == win_target);

        sum_base = win_first ? '0 : acc_sum;
        sum_next = sum_base + {12'd0, dec_code};
        min_next = (win_first || (dec_code < acc_min)) ? dec_code : acc_min;
        max_next = (win_first || (dec_code > acc_max)) ? dec_code : acc_max;

        // Compared with the last valid code, so changes across a window
        // boundary are counted in the new window.
        is_change = have_prev && (dec_code != currentCode);
        chg_base  = win_first ? '0 : acc_chg;
        chg_next  = (is_change && (chg_base != '1)) ? chg_base + 12'd1 : chg_base;

        result_load = complete && (!result.resultValid || result.resultReady);
        overrun_set = complete && result.resultValid && !result.resultReady;
    end

    always_ff @(posedge referenceClock or negedge reset_b) begin
        if (!reset_b) begin
            s1_row      <= '0;
            s1_col      <= '0;
            s1_valid    <= 1'b0;
            currentCode <= '0;
            codeValid   <= 1'b0;
            win_cnt     <= '0;
            win_log     <= '0;
            acc_sum     <= '0;
            acc_min     <= '0;
            acc_max     <= '0;
            acc_chg     <= '0;
            have_prev   <= 1'b0;
        end else if (!enable) begin
            s1_valid  <= 1'b0;
            codeValid <= 1'b0;
            win_cnt   <= '0;
            acc_sum   <= '0;
            acc_min   <= '0;
            acc_max   <= '0;
            acc_chg   <= '0;
            have_prev <= 1'b0;
        end else begin
            s1_row    <= dcoRowSelect;
            s1_col    <= dcoColumnSelect;
            s1_valid  <= 1'b1;
            codeValid <= sample_ok;
            if (sample_ok) begin
                currentCode <= dec_code;
                have_prev   <= 1'b1;
                if (win_first) begin
                    win_log <= log_in;
                end
                if (complete) begin
                    win_cnt <= '0;
                end else begin
                    win_cnt <= cnt_next;
                    acc_sum <= sum_next;
                    acc_min <= min_next;
                    acc_max <= max_next;
                    acc_chg <= chg_next;
                end
            end
        end
    end

    always_ff @(posedge referenceClock or negedge reset_b) begin
        if (!reset_b) begin
            result.resultValid   <= 1'b0;
            result.resultSum     <= '0;
            result.resultMin     <= '0;
            result.resultMax     <= '0;
            result.resultChanges <= '0;
        end else if (result_load) begin
            result.resultValid   <= 1'b1;
            result.resultSum     <= sum_next;
            result.resultMin     <= min_next;
            result.resultMax     <= max_next;
            result.resultChanges <= chg_next;
        end else if (result.resultValid && result.resultReady) begin
            result.resultValid <= 1'b0;
        end
    end

    // Set events take priority over clearFlags.
    always_ff @(posedge referenceClock or negedge reset_b) begin
        if (!reset_b) begin
            formatError <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (sample_bad) begin
                formatError <= 1'b1;
            end else if (clearFlags) begin
                formatError <= 1'b0;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (clearFlags) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
